// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - vending change dispenser: candy release, greedy coin return, handshake timeouts
//
// Ports:
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        dispense command, sampled only while idle
//   vend         captured with start: 1 = buy then return change, 0 = refund all credit
//   credit[5:0]  accumulated credit in cents, captured with start
//   candy_req    product-release request to the dispenser mechanism
//   candy_ack    dispenser acknowledge
//   coin_req     coin-eject request to the change mechanism
//   coin_type    coin to eject: 01 = 5c, 10 = 10c, 11 = 25c, 00 while coin_req is low
//   coin_ack     change mechanism acknowledge
//   change_left  cents still owed in the current transaction
//   busy         high whenever a transaction is in progress
//   done         one-cycle pulse on successful completion
//   err          one-cycle pulse on a rejected command or a handshake timeout
module change_dispense_ctrl #(
  parameter int PRICE   = 30,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       vend,
  input  logic [5:0] credit,
  output logic       candy_req,
  input  logic       candy_ack,
  output logic       coin_req,
  output logic [1:0] coin_type,
  input  logic       coin_ack,
  output logic [5:0] change_left,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [5:0] PRICE_C   = 6'(PRICE);
  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CANDY,
    S_CHANGE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] wait_inc;
  logic       bad_credit;
  logic       short_credit;

  // Largest coin that still fits in the amount owed; 00 when nothing is owed.
  function automatic logic [1:0] pick_coin(input logic [5:0] amt);
    if (amt >= 6'd25) begin
      return 2'b11;
    end else if (amt >= 6'd10) begin
      return 2'b10;
    end else if (amt != 6'd0) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  function automatic logic [5:0] coin_value(input logic [1:0] ct);
    case (ct)
      2'b01:   return 6'd5;
      2'b10:   return 6'd10;
      2'b11:   return 6'd25;
      default: return 6'd0;
    endcase
  endfunction

  // Saturating subtract so the owed amount can never wrap, even for a
  // coin larger than the remainder.
  function automatic logic [5:0] pay_out(input logic [5:0] amt, input logic [1:0] ct);
    logic [5:0] v;
    v = coin_value(ct);
    if (amt >= v) begin
      return amt - v;
    end else begin
      return 6'd0;
    end
  endfunction

  assign wait_inc     = wait_cnt + 4'd1;
  assign bad_credit   = ((credit % 6'd5) != 6'd0) || (credit > 6'd60);
  assign short_credit = credit < PRICE_C;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      candy_req   <= 1'b0;
      coin_req    <= 1'b0;
      coin_type   <= 2'b00;
      change_left <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wait_cnt    <= 4'd0;
    end else begin
      // Pulses last exactly one cycle unless a transition re-asserts them.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (bad_credit || (vend && short_credit)) begin
              state       <= S_ERR;
              err         <= 1'b1;
              change_left <= 6'd0;
            end else if (vend) begin
              state       <= S_CANDY;
              candy_req   <= 1'b1;
              change_left <= credit - PRICE_C;
              wait_cnt    <= 4'd0;
            end else begin
              state       <= S_CHANGE;
              change_left <= credit;
              wait_cnt    <= 4'd0;
              coin_req    <= (credit != 6'd0);
              coin_type   <= pick_coin(credit);
            end
          end
        end

        S_CANDY: begin
          // Acknowledge is checked first so it wins over a same-edge timeout.
          if (candy_ack) begin
            state     <= S_CHANGE;
            candy_req <= 1'b0;
            wait_cnt  <= 4'd0;
            coin_req  <= (change_left != 6'd0);
            coin_type <= pick_coin(change_left);
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == TIMEOUT_C) begin
              state     <= S_ERR;
              err       <= 1'b1;
              candy_req <= 1'b0;
            end
          end
        end

        S_CHANGE: begin
          // coin_req is high here exactly when something is still owed.
          if (change_left == 6'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (coin_ack) begin
            state       <= S_GAP;
            coin_req    <= 1'b0;
            coin_type   <= 2'b00;
            change_left <= pay_out(change_left, coin_type);
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == TIMEOUT_C) begin
              state     <= S_ERR;
              err       <= 1'b1;
              coin_req  <= 1'b0;
              coin_type <= 2'b00;
            end
          end
        end

        S_GAP: begin
          // One guaranteed low cycle on coin_req before the next coin.
          state     <= S_CHANGE;
          wait_cnt  <= 4'd0;
          coin_req  <= (change_left != 6'd0);
          coin_type <= pick_coin(change_left);
        end

        S_DONE, S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          candy_req <= 1'b0;
          coin_req  <= 1'b0;
          coin_type <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - self-checking bench for change_dispense_ctrl
module tb_change_dispense_ctrl;

  localparam int PRICE   = 30;
  localparam int TIMEOUT = 15;

  logic       clk;
  logic       rst;
  logic       start;
  logic       vend;
  logic [5:0] credit;
  logic       candy_req;
  logic       candy_ack;
  logic       coin_req;
  logic [1:0] coin_type;
  logic       coin_ack;
  logic [5:0] change_left;
  logic       busy;
  logic       done;
  logic       err;

  change_dispense_ctrl #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vend       (vend),
    .credit     (credit),
    .candy_req  (candy_req),
    .candy_ack  (candy_ack),
    .coin_req   (coin_req),
    .coin_type  (coin_type),
    .coin_ack   (coin_ack),
    .change_left(change_left),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic       candy;
    logic       coin;
    logic [1:0] ct;
    logic [5:0] left;
    logic       bsy;
    logic       dn;
    logic       er;
  } out_t;

  out_t       exp_q[$];
  logic [1:0] dut_coins[$];
  int         checks = 0;
  int         passed = 0;
  int         candy_hi = 0;
  int         coin_hi = 0;
  int         model_len = 0;
  bit         prev_coin = 1'b0;
  int         ack_lat = 0;
  bit         ack_stray = 1'b0;
  int         cand_cnt = 0;
  int         coin_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mechanism responder: acknowledge on the ack_lat-th cycle of a request
  // (never when ack_lat is 0), or hold both acknowledges high in stray mode.
  always @(negedge clk) begin
    if (ack_stray) begin
      candy_ack = 1'b1;
      coin_ack  = 1'b1;
      cand_cnt  = 0;
      coin_cnt  = 0;
    end else begin
      if (candy_req) cand_cnt++; else cand_cnt = 0;
      if (coin_req) coin_cnt++; else coin_cnt = 0;
      candy_ack = (ack_lat != 0) && (cand_cnt == ack_lat);
      coin_ack  = (ack_lat != 0) && (coin_cnt == ack_lat);
    end
  end

  // Per-cycle comparison against the model trace, plus request logging.
  always @(posedge clk) begin
    out_t a;
    out_t e;
    #3;
    if (candy_req) candy_hi++;
    if (coin_req) begin
      coin_hi++;
      if (!prev_coin) dut_coins.push_back(coin_type);
    end
    prev_coin = coin_req;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{candy_req, coin_req, coin_type, change_left, busy, done, err};
      checks++;
      if (a === e) passed++;
      else $display("FAIL cycle t=%0t actual candy=%b coin=%b type=%b left=%0d busy=%b done=%b err=%b required candy=%b coin=%b type=%b left=%0d busy=%b done=%b err=%b",
                    $time, a.candy, a.coin, a.ct, a.left, a.bsy, a.dn, a.er,
                    e.candy, e.coin, e.ct, e.left, e.bsy, e.dn, e.er);
    end
  end

  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  function automatic logic [1:0] code_of(input int v);
    case (v)
      5:       return 2'b01;
      10:      return 2'b10;
      25:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push(input bit cr, input bit qr, input int coin, input int left,
                      input bit b, input bit d, input bit e);
    out_t o;
    o.candy = cr;
    o.coin  = qr;
    o.ct    = code_of(coin);
    o.left  = 6'(left);
    o.bsy   = b;
    o.dn    = d;
    o.er    = e;
    exp_q.push_back(o);
  endtask

  // Expected output trace, one entry per cycle from the cycle after start
  // is taken up to and including the first idle cycle. lat = cycles each
  // request stays high before acknowledge; 0 = never acknowledged.
  task automatic model_txn(input int c, input bit v, input int lat);
    int rem;
    int coin;
    if ((c % 5) != 0 || c > 60 || (v && c < PRICE)) begin
      push(0, 0, 0, 0, 1, 0, 1);
      push(0, 0, 0, 0, 0, 0, 0);
      return;
    end
    rem = v ? c - PRICE : c;
    if (v) begin
      if (lat == 0) begin
        repeat (TIMEOUT) push(1, 0, 0, rem, 1, 0, 0);
        push(0, 0, 0, rem, 1, 0, 1);
        push(0, 0, 0, rem, 0, 0, 0);
        return;
      end
      repeat (lat) push(1, 0, 0, rem, 1, 0, 0);
    end
    while (rem > 0) begin
      coin = (rem >= 25) ? 25 : (rem >= 10) ? 10 : 5;
      if (lat == 0) begin
        repeat (TIMEOUT) push(0, 1, coin, rem, 1, 0, 0);
        push(0, 0, 0, rem, 1, 0, 1);
        push(0, 0, 0, rem, 0, 0, 0);
        return;
      end
      repeat (lat) push(0, 1, coin, rem, 1, 0, 0);
      rem -= coin;
      push(0, 0, 0, rem, 1, 0, 0);
    end
    push(0, 0, 0, 0, 1, 0, 0);
    push(0, 0, 0, 0, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a negedge; returns at the negedge after the trace is consumed.
  // In noisy mode start is held high with junk while the DUT is busy.
  task automatic wait_drain(input bit noisy);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      if (noisy) begin
        start  = 1'b1;
        vend   = 1'b1;
        credit = 6'd13;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout actual=%0d entries left required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_txn(input int c, input bit v, input int lat, input bit stray, input bit noisy);
    ack_lat   = lat;
    ack_stray = stray;
    model_txn(c, v, stray ? 1 : lat);
    model_len = exp_q.size();
    candy_hi  = 0;
    coin_hi   = 0;
    dut_coins.delete();
    credit = 6'(c);
    vend   = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(noisy);
    ack_stray = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    vend   = 1'b0;
    credit = 6'd0;
    candy_ack = 1'b0;
    coin_ack  = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Buy with 45: 10c then 5c back; start right after reset release.
    run_txn(45, 1, 2, 0, 0);
    lit("len45", model_len, 11);
    lit("candy45", candy_hi, 2);
    lit("ncoins45", dut_coins.size(), 2);
    if (dut_coins.size() == 2) begin
      lit("coin45_0", int'(dut_coins[0]), 2);
      lit("coin45_1", int'(dut_coins[1]), 1);
    end

    // Exact price: no change.
    run_txn(30, 1, 2, 0, 0);
    lit("candy30", candy_hi, 2);
    lit("ncoins30", dut_coins.size(), 0);

    // Cancel with 60: 25, 25, 10.
    run_txn(60, 0, 2, 0, 0);
    lit("len60", model_len, 12);
    lit("candy60", candy_hi, 0);
    lit("coinhi60", coin_hi, 6);
    lit("ncoins60", dut_coins.size(), 3);
    if (dut_coins.size() == 3) begin
      lit("coin60_0", int'(dut_coins[0]), 3);
      lit("coin60_1", int'(dut_coins[1]), 3);
      lit("coin60_2", int'(dut_coins[2]), 2);
    end

    // Rejections: insufficient, not a multiple of 5, above 60.
    run_txn(20, 1, 2, 0, 0);
    lit("candy20", candy_hi, 0);
    run_txn(23, 0, 2, 0, 0);
    lit("coinhi23", coin_hi, 0);
    run_txn(63, 0, 2, 0, 0);

    // Coin never acknowledged: timeout, owed amount kept.
    run_txn(55, 0, 0, 0, 0);
    lit("len55", model_len, TIMEOUT + 2);
    lit("coinhi55", coin_hi, TIMEOUT);
    lit("left55", int'(change_left), 55);

    // Candy never acknowledged.
    run_txn(45, 1, 0, 0, 0);
    lit("candyhi_to", candy_hi, TIMEOUT);

    // Acknowledge on the timeout edge wins.
    run_txn(35, 0, TIMEOUT, 0, 0);
    lit("ncoins35", dut_coins.size(), 2);

    // Acknowledges held high permanently, including while requests are low.
    run_txn(50, 1, 1, 1, 0);
    lit("ncoins50", dut_coins.size(), 2);

    // Start held high with junk while busy must be ignored.
    run_txn(40, 0, 3, 0, 1);

    // Zero refund completes without any coin.
    run_txn(0, 0, 1, 0, 0);
    lit("ncoins0", dut_coins.size(), 0);

    // Reset while a coin request is outstanding, then immediate restart.
    ack_lat = 0;
    repeat (3) push(0, 1, 25, 60, 1, 0, 0);
    credit = 6'd60;
    vend   = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(0);
    rst = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(15, 0, 1, 0, 0);
    lit("ncoins15", dut_coins.size(), 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 Parameter PRICE, default 30, product price in cents; SHALL be a multiple of 5 in 5..60.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles a request is held without acknowledge; range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  dispense command, sampled only in IDLE.
REQ-006 vend  input  1  captured with start: 1 = buy product then return change, 0 = cancel and refund full credit.
REQ-007 credit  input  6  accumulated credit in cents, captured with start.
REQ-008 candy_req  output  1  product-release request to dispenser mechanism.
REQ-009 candy_ack  input  1  mechanism acknowledge for candy_req.
REQ-010 coin_req  output  1  coin-eject request to change mechanism.
REQ-011 coin_type  output  2  coin to eject: 01 = 5c, 10 = 10c, 11 = 25c, 00 when coin_req low.
REQ-012 coin_ack  input  1  mechanism acknowledge for coin_req.
REQ-013 change_left  output  6  cents still owed in the current transaction.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 err  output  1  one-cycle pulse on rejected command or timeout.

Function
REQ-017 The FSM SHALL have states IDLE, CANDY, CHANGE, GAP, DONE, ERR; all outputs SHALL be decoded from state and registers only (Moore).
REQ-018 In IDLE with start=1, credit and vend SHALL be captured; start in any other state SHALL be ignored.
REQ-019 Captured credit not a multiple of 5, or above 60 -> next state ERR, change_left = 0.
REQ-020 vend=1 and credit < PRICE -> next state ERR (insufficient balance); no request issued.
REQ-021 vend=1 and credit >= PRICE -> change_left = credit - PRICE, next state CANDY.
REQ-022 vend=0 -> change_left = credit, next state CHANGE (refund; no candy_req ever issued).
REQ-023 CANDY: candy_req=1 until candy_ack sampled high; then next state CHANGE.
REQ-024 CHANGE with change_left = 0 -> next state DONE, coin_req stays 0.
REQ-025 CHANGE with change_left > 0: coin_req=1, coin_type greedy: >=25 -> 11, >=10 -> 10, else 01.
REQ-026 coin_type SHALL be stable while coin_req=1.
REQ-027 On coin_ack sampled high in CHANGE, change_left SHALL decrease by the coin value on that edge and next state SHALL be GAP.
REQ-028 GAP: one cycle with coin_req=0, then CHANGE; guarantees a low cycle between consecutive coin requests.
REQ-029 Acknowledges arriving while the matching request is low SHALL be ignored.
REQ-030 A 4-bit wait counter SHALL clear on entry to CANDY or CHANGE and increment each cycle the request is high without acknowledge.
REQ-031 When the wait counter reaches TIMEOUT with no acknowledge, next state ERR; the request drops; change_left holds its value for inspection.
REQ-032 Acknowledge on the same edge the counter reaches TIMEOUT SHALL take priority over timeout.
REQ-033 DONE: done=1 for one cycle, then IDLE; ERR: err=1 for one cycle, then IDLE.
REQ-034 done and err SHALL never be high in the same cycle.
REQ-035 The greedy sequence SHALL never overpay: change_left SHALL never underflow.

Reset
REQ-036 rst=1 at a rising edge SHALL force IDLE in any state, including mid-request.
REQ-037 After reset: candy_req, coin_req, done, err, busy = 0; coin_type = 00; change_left = 0; wait counter = 0.
REQ-038 start sampled on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-039 credit=45, vend=1, acks one cycle after request -> candy_req once; coins 10 then 01; change_left 15 -> 5 -> 0; done pulse.
REQ-040 credit=30, vend=1 -> candy_req once; no coin_req; done pulse.
REQ-041 credit=60, vend=0 (cancel) -> no candy_req; coins 11, 11, 10 with a GAP low cycle between each; change_left 60 -> 35 -> 10 -> 0; done pulse.
REQ-042 credit=20, vend=1; and credit=23, vend=0 -> err pulse one cycle after start; no request; busy returns 0.
REQ-043 credit=55, vend=0, coin_ack held 0 -> coin_req high exactly TIMEOUT cycles, then err pulse; change_left stays 55.
REQ-044 rst asserted while coin_req=1 -> all outputs at reset values next cycle; new start accepted right after rst drops.
